// File: rtl/boss_fire_sched.sv
// ---------------------------------------------------------------------------
// boss_fire_sched
//
// Attack-pattern scheduler for the boss fight. Cycles through
// IDLE -> SPREAD (volleys of five spread bullets) -> BIG (one big bullet)
// -> COOLDOWN -> SPREAD ... and never launches into a slot whose bullet is
// still in flight.
//
// Optional feature macro: BOSS_RAGE_EN
//   When defined and 0 < boss_hp < RAGE_HP, the spread period and big-hold
//   are halved (minimum 1 cycle) and BIG returns straight to SPREAD.
//
// Ports:
//   clk22        in   game tick clock
//   rst          in   synchronous, active-high reset
//   boss         in   boss fight active; low acts like rst
//   boss_hp[7:0] in   boss HP; 0 = defeated (clears state, keeps pattern_cnt)
//   slot_busy[5:0] in [0] big bullet in flight, [5:1] spread bullets
//   fire[5:0]    out  one-cycle registered launch strobe per slot
//   phase[1:0]   out  0 IDLE, 1 SPREAD, 2 BIG, 3 COOLDOWN
//   pattern_cnt[7:0] out completed full patterns, saturating at 255
//   state_dbg[2:0] out raw FSM state for debug/checkers
//
// Handshake: there is no valid/ready pair here. fire[i] is a single-cycle
// strobe; it is only raised when slot_busy[i] was low on the deciding edge.
// ---------------------------------------------------------------------------
module boss_fire_sched #(
    parameter int SPREAD_PERIOD  = 8,
    parameter int SPREAD_VOLLEYS = 4,
    parameter int BIG_HOLD       = 12,
    parameter int COOLDOWN       = 16,
    parameter int RAGE_HP        = 32
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       boss,
    input  logic [7:0] boss_hp,
    input  logic [5:0] slot_busy,
    output logic [5:0] fire,
    output logic [1:0] phase,
    output logic [7:0] pattern_cnt,
    output logic [2:0] state_dbg
);

`ifdef BOSS_RAGE_EN
    localparam bit RAGE_ON = 1'b1;
`else
    localparam bit RAGE_ON = 1'b0;
`endif

    // Timer load values (timer counts load..0, so a load of N-1 spans N cycles).
    localparam int SPREAD_HALF = ((SPREAD_PERIOD >> 1) < 1) ? 1 : (SPREAD_PERIOD >> 1);
    localparam int HOLD_HALF   = ((BIG_HOLD >> 1) < 1) ? 1 : (BIG_HOLD >> 1);

    localparam logic [7:0] SPREAD_LOAD      = 8'(SPREAD_PERIOD - 1);
    localparam logic [7:0] SPREAD_LOAD_RAGE = 8'(SPREAD_HALF - 1);
    localparam logic [7:0] HOLD_LOAD        = 8'(BIG_HOLD - 1);
    localparam logic [7:0] HOLD_LOAD_RAGE   = 8'(HOLD_HALF - 1);
    localparam logic [7:0] COOL_LOAD        = 8'(COOLDOWN - 1);
    localparam logic [7:0] VOLLEY_LAST      = 8'(SPREAD_VOLLEYS - 1);
    localparam logic [7:0] RAGE_THRESH      = 8'(RAGE_HP);

    // BIG is split into a wait-for-slot state and a hold state so that the
    // big bullet can only be launched once per visit.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPREAD   = 3'd1,
        S_BIG_WAIT = 3'd2,
        S_BIG_HOLD = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    state_t     state_q, state_n;
    logic [7:0] timer_q, timer_n;
    logic [7:0] volley_q, volley_n;
    logic [7:0] pcnt_n;
    logic [5:0] fire_n;

    // Rage is evaluated combinationally, so every timer load sees the
    // current HP.
    logic       rage;
    logic [7:0] spread_load;
    logic [7:0] hold_load;
    logic [7:0] pcnt_inc;

    assign rage        = RAGE_ON && (boss_hp < RAGE_THRESH);
    assign spread_load = rage ? SPREAD_LOAD_RAGE : SPREAD_LOAD;
    assign hold_load   = rage ? HOLD_LOAD_RAGE   : HOLD_LOAD;
    assign pcnt_inc    = (pattern_cnt == 8'hFF) ? pattern_cnt : pattern_cnt + 8'd1;

    always_ff @(posedge clk22) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            volley_q    <= 8'd0;
            pattern_cnt <= 8'd0;
            fire        <= 6'd0;
        end else begin
            state_q     <= state_n;
            timer_q     <= timer_n;
            volley_q    <= volley_n;
            pattern_cnt <= pcnt_n;
            fire        <= fire_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q;
        volley_n = volley_q;
        pcnt_n   = pattern_cnt;
        fire_n   = 6'd0;

        if (!boss || (boss_hp == 8'd0)) begin
            // Boss gone: same as reset, except a defeated boss keeps its
            // completed-pattern count.
            state_n  = S_IDLE;
            timer_n  = 8'd0;
            volley_n = 8'd0;
            if (!boss) begin
                pcnt_n = 8'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n = S_SPREAD;
                    timer_n = spread_load;
                end

                S_SPREAD: begin
                    if (timer_q == 8'd0) begin
                        // A volley counts even when all slots are busy.
                        fire_n = {~slot_busy[5:1], 1'b0};
                        if (volley_q == VOLLEY_LAST) begin
                            state_n  = S_BIG_WAIT;
                            volley_n = 8'd0;
                            timer_n  = 8'd0;
                        end else begin
                            volley_n = volley_q + 8'd1;
                            timer_n  = spread_load;
                        end
                    end else begin
                        timer_n = timer_q - 8'd1;
                    end
                end

                S_BIG_WAIT: begin
                    if (!slot_busy[0]) begin
                        fire_n  = 6'b000001;
                        state_n = S_BIG_HOLD;
                        timer_n = hold_load;
                    end
                end

                S_BIG_HOLD: begin
                    if (timer_q == 8'd0) begin
                        if (rage) begin
                            state_n = S_SPREAD;
                            timer_n = spread_load;
                            pcnt_n  = pcnt_inc;
                        end else begin
                            state_n = S_COOLDOWN;
                            timer_n = COOL_LOAD;
                        end
                    end else begin
                        timer_n = timer_q - 8'd1;
                    end
                end

                S_COOLDOWN: begin
                    if (timer_q == 8'd0) begin
                        state_n = S_SPREAD;
                        timer_n = spread_load;
                        pcnt_n  = pcnt_inc;
                    end else begin
                        timer_n = timer_q - 8'd1;
                    end
                end

                default: begin
                    state_n = S_IDLE;
                    timer_n = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_SPREAD:               phase = 2'd1;
            S_BIG_WAIT, S_BIG_HOLD: phase = 2'd2;
            S_COOLDOWN:             phase = 2'd3;
            default:                phase = 2'd0;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_boss_fire_sched.sv
// ---------------------------------------------------------------------------
// Testbench for boss_fire_sched (default parameters).
// Each vector drives inputs, pushes its expected {fire, phase, pattern_cnt}
// onto exp_q, advances the given number of clock edges and then pops and
// compares against the DUT, sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_boss_fire_sched;

    // ---------------- clock / reset ----------------
    logic       clk22 = 1'b0;
    logic       rst;
    logic       boss;
    logic [7:0] boss_hp;
    logic [5:0] slot_busy;
    logic [5:0] fire;
    logic [1:0] phase;
    logic [7:0] pattern_cnt;
    logic [2:0] state_dbg;

    always #5 clk22 = ~clk22;

    boss_fire_sched dut (
        .clk22       (clk22),
        .rst         (rst),
        .boss        (boss),
        .boss_hp     (boss_hp),
        .slot_busy   (slot_busy),
        .fire        (fire),
        .phase       (phase),
        .pattern_cnt (pattern_cnt),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passed = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int         adv;
        logic       rst;
        logic       boss;
        logic [7:0] hp;
        logic [5:0] busy;
        logic [5:0] fire;
        logic [1:0] phase;
        logic [7:0] pcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int adv, logic r, logic b, logic [7:0] hp,
                                logic [5:0] busy, logic [5:0] f,
                                logic [1:0] ph, logic [7:0] pc);
        vec_t v;
        v.adv = adv; v.rst = r; v.boss = b; v.hp = hp; v.busy = busy;
        v.fire = f; v.phase = ph; v.pcnt = pc;
        return v;
    endfunction

    task automatic advance(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk22);
            #1;
        end
    endtask

    task automatic compare_head(string name);
        logic [15:0] exp_v;
        logic [15:0] got_v;
        got_v = {fire, phase, pattern_cnt};
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s: scoreboard empty, got fire=%b phase=%0d pcnt=%0d",
                     name, fire, phase, pattern_cnt);
            return;
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v === exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s: got fire=%b phase=%0d pcnt=%0d, expected fire=%b phase=%0d pcnt=%0d",
                     name, got_v[15:10], got_v[9:8], got_v[7:0],
                     exp_v[15:10], exp_v[9:8], exp_v[7:0]);
        end
    endtask

    task automatic apply(vec_t v, string name);
        rst       = v.rst;
        boss      = v.boss;
        boss_hp   = v.hp;
        slot_busy = v.busy;
        exp_q.push_back({v.fire, v.phase, v.pcnt});
        advance(v.adv);
        compare_head(name);
    endtask

    task automatic run_table(string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("%s_%0d", tag, i));
        end
        vecs.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; boss = 1'b1; boss_hp = 8'd100; slot_busy = 6'd0;

        // Reset, then a full nominal pattern starting at SPREAD entry edge E.
        vecs.push_back(mk(2,  1, 1, 100, 6'b000000, 6'b000000, 2'd0, 0)); // reset
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd1, 0)); // E
        vecs.push_back(mk(7,  0, 1, 100, 6'b000000, 6'b000000, 2'd1, 0)); // cycle 8
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b111110, 2'd1, 0)); // cycle 9
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd1, 0)); // one-cycle strobe
        vecs.push_back(mk(7,  0, 1, 100, 6'b000000, 6'b111110, 2'd1, 0)); // cycle 17
        vecs.push_back(mk(8,  0, 1, 100, 6'b000000, 6'b111110, 2'd1, 0)); // cycle 25
        vecs.push_back(mk(8,  0, 1, 100, 6'b000000, 6'b111110, 2'd2, 0)); // cycle 33, BIG
        // Big bullet held in flight for 20 cycles.
        vecs.push_back(mk(20, 0, 1, 100, 6'b000001, 6'b000000, 2'd2, 0));
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000001, 2'd2, 0)); // big strobe
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd2, 0));
        vecs.push_back(mk(10, 0, 1, 100, 6'b000000, 6'b000000, 2'd2, 0));
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd3, 0)); // 12 after strobe
        vecs.push_back(mk(15, 0, 1, 100, 6'b000000, 6'b000000, 2'd3, 0));
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd1, 1)); // pattern done
        // Slot masking on the second pattern.
        vecs.push_back(mk(8,  0, 1, 100, 6'b001010, 6'b110100, 2'd1, 1));
        vecs.push_back(mk(1,  0, 1, 100, 6'b001010, 6'b000000, 2'd1, 1));
        vecs.push_back(mk(7,  0, 1, 100, 6'b001010, 6'b110100, 2'd1, 1));
        vecs.push_back(mk(8,  0, 1, 100, 6'b001010, 6'b110100, 2'd1, 1));
        // Boss defeated during a strobe: clears, keeps pattern_cnt.
        vecs.push_back(mk(1,  0, 1,   0, 6'b001010, 6'b000000, 2'd0, 1));
        vecs.push_back(mk(1,  0, 1, 100, 6'b001010, 6'b000000, 2'd1, 1));
        vecs.push_back(mk(8,  0, 1, 100, 6'b000000, 6'b111110, 2'd1, 1));
        // Boss low during a strobe: full clear, then restart.
        vecs.push_back(mk(1,  0, 0, 100, 6'b000000, 6'b000000, 2'd0, 0));
        vecs.push_back(mk(3,  0, 0, 100, 6'b000000, 6'b000000, 2'd0, 0));
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd1, 0));
        // All slots busy: volleys still count, no strobes.
        vecs.push_back(mk(8,  0, 1, 100, 6'b111111, 6'b000000, 2'd1, 0));
        vecs.push_back(mk(24, 0, 1, 100, 6'b111111, 6'b000000, 2'd2, 0));
        vecs.push_back(mk(5,  0, 1, 100, 6'b111111, 6'b000000, 2'd2, 0));
        vecs.push_back(mk(1,  0, 1, 100, 6'b111110, 6'b000001, 2'd2, 0));
        vecs.push_back(mk(11, 0, 1, 100, 6'b000000, 6'b000000, 2'd2, 0)); // no relaunch
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd3, 0));
        run_table("nominal");

        // pattern_cnt saturation: one pattern is 61 edges with no busy slots.
        vecs.push_back(mk(1, 1, 1, 100, 6'b000000, 6'b000000, 2'd0, 0));
        vecs.push_back(mk(1, 0, 1, 100, 6'b000000, 6'b000000, 2'd1, 0));   // E
        vecs.push_back(mk(61 * 254 - 1, 0, 1, 100, 6'b000000, 6'b000000, 2'd3, 253));
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd1, 254));
        vecs.push_back(mk(60, 0, 1, 100, 6'b000000, 6'b000000, 2'd3, 254));
        vecs.push_back(mk(1,  0, 1, 100, 6'b000000, 6'b000000, 2'd1, 255));
        vecs.push_back(mk(61, 0, 1, 100, 6'b000000, 6'b000000, 2'd1, 255)); // held
        run_table("saturate");

`ifdef BOSS_RAGE_EN
        // Low HP: 4-cycle volleys, 6-cycle hold, BIG straight back to SPREAD.
        vecs.push_back(mk(1,  1, 1, 10, 6'b000000, 6'b000000, 2'd0, 0));
        vecs.push_back(mk(1,  0, 1, 10, 6'b000000, 6'b000000, 2'd1, 0));   // E
        vecs.push_back(mk(3,  0, 1, 10, 6'b000000, 6'b000000, 2'd1, 0));
        vecs.push_back(mk(1,  0, 1, 10, 6'b000000, 6'b111110, 2'd1, 0));   // E+4
        vecs.push_back(mk(12, 0, 1, 10, 6'b000000, 6'b111110, 2'd2, 0));   // E+16
        vecs.push_back(mk(1,  0, 1, 10, 6'b000000, 6'b000001, 2'd2, 0));
        vecs.push_back(mk(5,  0, 1, 10, 6'b000000, 6'b000000, 2'd2, 0));
        vecs.push_back(mk(1,  0, 1, 10, 6'b000000, 6'b000000, 2'd1, 1));   // no cooldown
        vecs.push_back(mk(4,  0, 1, 10, 6'b000000, 6'b111110, 2'd1, 1));
        run_table("rage");
`endif

        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/boss_fire_sched.md
# boss_fire_sched

Attack-pattern scheduler for the boss fight. It sequences when each of the six boss bullet slots (one big bullet, five spread bullets) is launched, and arbitrates launches against slot occupancy so that a slot still in flight is never relaunched. It sits between the boss/stage control logic and the boss bullet datapath. It drives per-slot one-cycle launch strobes and consumes the datapath's per-slot "bullet exists" flags.

## Interface
Parameters:
- SPREAD_PERIOD, 8: cycles between spread volleys (1..255)
- SPREAD_VOLLEYS, 4: volleys per SPREAD phase (1..255)
- BIG_HOLD, 12: cycles spent in BIG after the big bullet launches (1..255)
- COOLDOWN, 16: cycles of silence before the pattern repeats (1..255)
- RAGE_HP, 32: HP threshold for rage mode (only used with BOSS_RAGE_EN)

Ports:
- clk22  in  1  game tick clock
- rst  in  1  reset, synchronous, active-high
- boss  in  1  boss fight active; low behaves exactly like rst
- boss_hp  in  8  current boss HP; 0 = boss defeated
- slot_busy  in  6  [0] big bullet in flight, [5:1] spread bullets 1..5 in flight
- fire  out  6  one-cycle launch strobe per slot, same bit mapping as slot_busy
- phase  out  2  0 IDLE, 1 SPREAD, 2 BIG, 3 COOLDOWN
- pattern_cnt  out  8  completed full patterns, saturates at 255

## Operation
- **Reset / boss low / boss_hp==0.** On the next edge: state IDLE, fire=0, phase=0, timer=0, volley counter=0, pattern_cnt=0. The exception is boss_hp==0, which keeps pattern_cnt.
- **IDLE.** When boss=1 and boss_hp!=0, go to SPREAD and load timer=SPREAD_PERIOD-1.
- **SPREAD.**
  - Timer decrements each cycle.
  - When timer==0 is sampled, the volley fires: fire[5:1] <= ~slot_busy[5:1], fire[0] <= 0. Timer reloads and the volley counter increments.
  - A volley counts even if every slot is busy, in which case no strobe is issued.
  - After the SPREAD_VOLLEYS-th volley, go to BIG. The volley counter clears.
- **BIG.**
  - While slot_busy[0]=1, wait with no timeout.
  - On the first cycle slot_busy[0]=0 is sampled: fire[0] <= 1 and timer loads BIG_HOLD-1.
  - When the timer reaches 0, go to COOLDOWN and load timer=COOLDOWN-1.
  - fire[0] is issued exactly once per BIG visit.
- **COOLDOWN.**
  - fire stays 0.
  - When timer==0, go to SPREAD, reload timer=SPREAD_PERIOD-1, and increment pattern_cnt (holds at 255).
- **fire rules.** fire is registered and high for exactly one cycle per launch. fire[i] is never high while slot_busy[i] was high in the deciding cycle.
- **Arithmetic.** Timer and counters are 8 bits. Load values are parameter-1; no wrap occurs because parameters are ≥1.

## Timing
- Entering SPREAD on edge E: the first volley strobe is visible in the cycle after edge E+SPREAD_PERIOD. Subsequent volleys follow every SPREAD_PERIOD cycles.
- Big-bullet strobe latency is 1 cycle from sampling slot_busy[0]=0 in BIG.
- phase updates on the same edge as the state change. The last SPREAD strobe and phase=2 appear in the same cycle.
- A reset, boss low or boss_hp==0 asserted during a strobe clears fire on the next edge. Strobes are never stretched.
- If slot_busy changes in the same cycle as a volley decision, the value sampled on that edge decides.

## Configuration
- Macro: BOSS_RAGE_EN.
- **Defined.** When boss_hp < RAGE_HP (and nonzero):
  - SPREAD_PERIOD and BIG_HOLD load values become (param>>1), with a minimum of 1, minus 1.
  - BIG goes directly to SPREAD, skipping COOLDOWN. pattern_cnt increments on that transition.
  - The threshold is sampled at each timer load.
- **Undefined.** boss_hp is used only for the ==0 check; timing is always nominal.

## Test plan
- **Reset.** rst=1 for 2 cycles with boss=1 -> fire=0, phase=0, pattern_cnt=0. After release, phase=1 on the next edge.
- **Spread, defaults, slot_busy=0.** fire=6'b111110 in cycles 9, 17, 25 and 33 after SPREAD entry. phase=2 in the same cycle as the 4th strobe.
- **Slot masking.** slot_busy=6'b001010 constant -> each volley fire=6'b110100. fire[0] is never set in SPREAD.
- **Big wait.** Hold slot_busy[0]=1 for 20 cycles in BIG, then release -> fire=6'b000001 one cycle later, phase=3 after 12 more cycles, phase=1 and pattern_cnt=1 after 16 more.
- **Abort.** Drop boss to 0 mid-SPREAD on the cycle a strobe is high -> the next cycle has fire=0, phase=0, pattern_cnt=0. Raising boss restarts at SPREAD.
- **Rage (BOSS_RAGE_EN).** boss_hp=10 -> volleys every 4 cycles, BIG hold of 6 cycles, BIG→SPREAD directly. With boss_hp=200 the timing is nominal.
